// File: rtl/pkt_ff_pkg.sv
// Shared types and Gray-code helpers for the packet FIFO pointer logic.
package pkt_ff_pkg;

  localparam int PKT_FF_PTR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_PKT = 2'd1,
    ST_DROP   = 2'd2
  } wstate_e;

  function automatic logic [31:0] bin2gry(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits of narrower pointers are zero, so a 32-bit walk is exact.
  function automatic logic [31:0] gry2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pkt_ff_wptr.sv
// Write-side pointer controller: speculative working pointer, committed packet
// pointer exported in Gray code, full/almost-full against the synced read pointer.
module pkt_ff_wptr
  import pkt_ff_pkg::*;
#(
  parameter int PTR_W    = PKT_FF_PTR_W,
  parameter int AFULL_TH = (1 << (PTR_W - 1)) - 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_sop,
  input  logic             wr_eop,
  input  logic             wr_err,
  input  logic [PTR_W-1:0] rptr_gry_sync,
  output logic             ram_wr_en,
  output logic [PTR_W-2:0] ram_waddr,
  output logic [PTR_W-1:0] wptr,
  output logic             full,
  output logic             afull,
  output logic             ovrflw,
  output logic [1:0]       dbg_state
);

  localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

  wstate_e          state_q, state_d;
  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] cbin_q, cbin_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic             afull_q, afull_d;
  logic             ovrflw_q, ovrflw_d;

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] occ;
  logic             full_w, full_c;
  logic [PTR_W-1:0] base, base_next;
  logic             base_full;
  logic             take;
  logic             accept;

  always_comb begin
    rbin   = PTR_W'(gry2bin(32'(rptr_gry_sync)));
    occ    = wbin_q - rbin;
    full_w = (wbin_q[PTR_W-1] != rbin[PTR_W-1]) &&
             (wbin_q[PTR_W-2:0] == rbin[PTR_W-2:0]);
    full_c = (cbin_q[PTR_W-1] != rbin[PTR_W-1]) &&
             (cbin_q[PTR_W-2:0] == rbin[PTR_W-2:0]);
  end

  // A sop inside an open packet restarts writing from the committed pointer.
  always_comb begin
    base      = wbin_q;
    base_full = full_w;
    if (state_q == ST_WR_PKT && wr_sop) begin
      base      = cbin_q;
      base_full = full_c;
    end
    base_next = base + ONE;
  end

  always_comb begin
    wbin_d   = wbin_q;
    cbin_d   = cbin_q;
    state_d  = state_q;
    ovrflw_d = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_WR_PKT: take = wr_en;
      default:   take = wr_en && wr_sop;
    endcase
    if (take) begin
      if (!base_full) begin
        accept = 1'b1;
        if (wr_eop) begin
          state_d = ST_IDLE;
          if (wr_err) begin
            wbin_d = cbin_q;
          end else begin
            wbin_d = base_next;
            cbin_d = base_next;
          end
        end else begin
          wbin_d  = base_next;
          state_d = ST_WR_PKT;
        end
      end else begin
        ovrflw_d = 1'b1;
        wbin_d   = cbin_q;
        state_d  = wr_eop ? ST_IDLE : ST_DROP;
      end
    end else if (state_q == ST_DROP && wr_en && wr_eop) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    wptr_d  = PTR_W'(bin2gry(32'(cbin_d)));
    afull_d = (occ >= PTR_W'(AFULL_TH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wbin_q   <= '0;
      cbin_q   <= '0;
      wptr_q   <= '0;
      afull_q  <= 1'b0;
      ovrflw_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wbin_q   <= wbin_d;
      cbin_q   <= cbin_d;
      wptr_q   <= wptr_d;
      afull_q  <= afull_d;
      ovrflw_q <= ovrflw_d;
    end
  end

  assign ram_wr_en = accept;
  assign ram_waddr = base[PTR_W-2:0];
  assign full      = full_w;
  assign wptr      = wptr_q;
  assign afull     = afull_q;
  assign ovrflw    = ovrflw_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pkt_ff_wptr.sv
// Directed bench for pkt_ff_wptr at PTR_W=4 (depth 8, almost-full at 4).
module tb_pkt_ff_wptr;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_sop, wr_eop, wr_err;
  logic [PW-1:0] rptr_gry_sync;
  logic          ram_wr_en;
  logic [PW-2:0] ram_waddr;
  logic [PW-1:0] wptr;
  logic          full, afull, ovrflw;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  pkt_ff_wptr #(.PTR_W(PW), .AFULL_TH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_err(wr_err),
    .rptr_gry_sync(rptr_gry_sync),
    .ram_wr_en(ram_wr_en), .ram_waddr(ram_waddr), .wptr(wptr),
    .full(full), .afull(afull), .ovrflw(ovrflw), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    wr_en  = 1'b0;
    wr_sop = 1'b0;
    wr_eop = 1'b0;
    wr_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rptr_gry_sync = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive one word, check the same-cycle strobe/address, then step one clock.
  task automatic word(input string tag, input logic en, input logic sop, input logic eop,
                      input logic err, input logic exp_we, input logic [PW-2:0] exp_addr);
    wr_en  = en;
    wr_sop = sop;
    wr_eop = eop;
    wr_err = err;
    #1;
    chk({tag, ".we"}, 32'(ram_wr_en), 32'(exp_we));
    if (exp_we) chk({tag, ".addr"}, 32'(ram_waddr), 32'(exp_addr));
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    rptr_gry_sync = '0;
    #12;
    chk("rst.wptr",   32'(wptr),      32'h0);
    chk("rst.afull",  32'(afull),     32'h0);
    chk("rst.ovrflw", 32'(ovrflw),    32'h0);
    chk("rst.full",   32'(full),      32'h0);
    chk("rst.state",  32'(dbg_state), 32'h0);
    chk("rst.we",     32'(ram_wr_en), 32'h0);

    // 3-word packet
    do_reset();
    word("t1w0", 1, 1, 0, 0, 1, 3'd0);
    chk("t1.wptr_open", 32'(wptr), 32'h0);
    chk("t1.state_wr",  32'(dbg_state), 32'h1);
    word("t1w1", 1, 0, 0, 0, 1, 3'd1);
    word("t1w2", 1, 0, 1, 0, 1, 3'd2);
    chk("t1.wptr",  32'(wptr), 32'b0010);
    chk("t1.state", 32'(dbg_state), 32'h0);
    idle();
    chk("t1.afull", 32'(afull), 32'h0);

    // stray word without sop, then single-word packet
    do_reset();
    word("t2ign", 1, 0, 0, 0, 0, 3'd0);
    word("t2w0",  1, 1, 1, 0, 1, 3'd0);
    chk("t2.wptr", 32'(wptr), 32'b0001);

    // errored 4-word packet is discarded, next packet reuses address 0
    do_reset();
    word("t3w0", 1, 1, 0, 0, 1, 3'd0);
    word("t3w1", 1, 0, 0, 0, 1, 3'd1);
    word("t3w2", 1, 0, 0, 0, 1, 3'd2);
    word("t3w3", 1, 0, 1, 1, 1, 3'd3);
    chk("t3.wptr_err", 32'(wptr), 32'h0);
    word("t3n", 1, 1, 1, 0, 1, 3'd0);
    chk("t3.wptr_next", 32'(wptr), 32'b0001);

    // fill to 7, then overflow in the middle of a 3-word packet
    do_reset();
    for (int i = 0; i < 7; i++)
      word($sformatf("t4c%0d", i), 1, (i == 0), (i == 6), 0, 1, 3'(i));
    chk("t4.wptr7", 32'(wptr), 32'b0100);
    idle();
    chk("t4.afull", 32'(afull), 32'h1);
    chk("t4.full0", 32'(full), 32'h0);
    word("t4a", 1, 1, 0, 0, 1, 3'd7);
    chk("t4.full1", 32'(full), 32'h1);
    chk("t4.ovf0",  32'(ovrflw), 32'h0);
    word("t4b", 1, 0, 0, 0, 0, 3'd0);
    chk("t4.ovf1",   32'(ovrflw), 32'h1);
    chk("t4.drop",   32'(dbg_state), 32'h2);
    word("t4c", 1, 0, 1, 0, 0, 3'd0);
    chk("t4.ovf2",   32'(ovrflw), 32'h0);
    chk("t4.idle",   32'(dbg_state), 32'h0);
    chk("t4.wptr",   32'(wptr), 32'b0100);
    chk("t4.full2",  32'(full), 32'h0);

    // pointer wrap: commit to 14, then a 4-word packet across the wrap
    do_reset();
    for (int i = 0; i < 6; i++)
      word($sformatf("t5a%0d", i), 1, (i == 0), (i == 5), 0, 1, 3'(i));
    chk("t5.wptr6", 32'(wptr), 32'b0101);
    rptr_gry_sync = 4'b0101;
    for (int i = 0; i < 8; i++)
      word($sformatf("t5b%0d", i), 1, (i == 0), (i == 7), 0, 1, 3'((6 + i) % 8));
    chk("t5.wptr14", 32'(wptr), 32'b1001);
    chk("t5.full14", 32'(full), 32'h1);
    rptr_gry_sync = 4'b1010;
    #1;
    chk("t5.free", 32'(full), 32'h0);
    word("t5c0", 1, 1, 0, 0, 1, 3'd6);
    word("t5c1", 1, 0, 0, 0, 1, 3'd7);
    word("t5c2", 1, 0, 0, 0, 1, 3'd0);
    word("t5c3", 1, 0, 1, 0, 1, 3'd1);
    chk("t5.wptr2", 32'(wptr), 32'b0011);
    idle();
    chk("t5.afull", 32'(afull), 32'h1);

    // sop inside an open packet restarts at the committed pointer
    do_reset();
    word("t6w0", 1, 1, 0, 0, 1, 3'd0);
    word("t6w1", 1, 0, 0, 0, 1, 3'd1);
    word("t6r0", 1, 1, 0, 0, 1, 3'd0);
    chk("t6.state", 32'(dbg_state), 32'h1);
    word("t6r1", 1, 0, 1, 0, 1, 3'd1);
    chk("t6.wptr2", 32'(wptr), 32'b0011);
    chk("t6.afull0", 32'(afull), 32'h0);
    word("t6p0", 1, 1, 0, 0, 1, 3'd2);
    word("t6p1", 1, 0, 1, 0, 1, 3'd3);
    chk("t6.wptr4", 32'(wptr), 32'b0110);
    chk("t6.afull1", 32'(afull), 32'h0);
    idle();
    chk("t6.afull2", 32'(afull), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
